serv_fetch_seq: RTL
===================

Name: serv_fetch_seq

Overview:
Instruction-cycle sequencer that drives the instruction-bus handshake and strobes the registered instruction decoder. It steps the bit-serial datapath through the optional init stage, the optional data-bus wait and the execute stage. It sits between the ibus/dbus Wishbone ports and the decoder/state logic, and produces the bit counter and stage qualifiers that the serial datapath consumes.

Parameters:
W, 1, serial datapath width in bits per cycle; legal values 1 or 4; each stage lasts 32/W cycles.
TIMEOUT, 255, bus watchdog limit in cycles; used only when the optional feature is compiled in; 8-bit range.

Ports:
clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
o_ibus_cyc  out  1  instruction fetch request
i_ibus_ack  in  1  instruction bus acknowledge
o_dec_en  out  1  decoder capture strobe (instruction word valid)
i_two_stage_op  in  1  decoder: instruction needs init stage
i_dbus_en  in  1  decoder: instruction accesses data bus
o_dbus_cyc  out  1  data bus request
i_dbus_ack  in  1  data bus acknowledge
o_cnt  out  5  serial bit index
o_cnt_en  out  1  serial datapath active
o_init  out  1  high during init stage
o_done  out  1  last cycle of execute stage
o_pc_en  out  1  PC update enable (equals o_done)
o_bus_err  out  1  watchdog expiry pulse (optional feature)

Behaviour:
- States: IDLE, FETCH, DECODE, INIT, MEM, EXEC. i_rst_n low forces IDLE immediately, independent of clk.
- Reset values: all outputs 0, o_cnt=0, watchdog count 0.
- IDLE -> FETCH on the first posedge after reset release.
- FETCH: o_ibus_cyc=1.
  - o_dec_en = i_ibus_ack while in FETCH (combinational, same cycle as ack).
  - On ack, next state is DECODE; o_ibus_cyc drops the following cycle.
- DECODE: one cycle; decoder outputs are valid here.
  - i_two_stage_op=1 -> INIT; else -> EXEC.
  - o_cnt_en=0.
- INIT: o_cnt_en=1, o_init=1.
  - o_cnt advances by W each cycle: 0,1..31 for W=1; 0,4..28 for W=4.
  - After the last index, o_cnt wraps to 0.
  - i_dbus_en=1 -> MEM; else -> EXEC.
- MEM: o_dbus_cyc=1, o_cnt_en=0, o_cnt held at 0. On i_dbus_ack -> EXEC; o_dbus_cyc drops the next cycle.
- EXEC: o_cnt_en=1, o_init=0, same counting as INIT.
  - Last index: o_done=1 and o_pc_en=1 for exactly one cycle.
  - Next state is FETCH, with o_cnt=0.
- Acks outside their owning state (ibus ack outside FETCH, dbus ack outside MEM) are ignored. A single cycle never has o_ibus_cyc and o_dbus_cyc both high.
- Ack in the same cycle that a request is first asserted is accepted (zero-wait-state bus).
- i_two_stage_op and i_dbus_en are sampled only at the DECODE and end-of-INIT transitions.
- Minimum cycles per instruction with zero-wait acks:
  - single-stage: 1 + 1 + 32/W;
  - two-stage without memory: 1 + 1 + 2*(32/W);
  - two-stage with memory: add 1 (MEM).
- Reset asserted mid-stage: counter and state are cleared asynchronously. Any outstanding bus cycle is abandoned (cyc low at once). Fetch restarts after release.

Optional Feature:
- Macro: SERV_FETCH_SEQ_WATCHDOG_EN.
- With the macro: an 8-bit counter clears on entry to FETCH/MEM and increments each cycle without ack. When it equals TIMEOUT:
  - o_bus_err=1 for one cycle;
  - the cyc outputs drop;
  - state returns to IDLE, then FETCH (retry from fetch).
- Without the macro: no counter; o_bus_err tied 0; waits forever.

Test Plan:
- Reset release, ack held high, i_two_stage_op=0, W=1 -> o_ibus_cyc high at cycle 1, o_dec_en pulse at cycle 1, DECODE at cycle 2, o_cnt_en cycles 3-34, o_done at cycle 34 with o_cnt=31, o_ibus_cyc again at cycle 35.
- W=4, two-stage, i_dbus_en=1, dbus ack after 3 wait cycles -> o_init high 8 cycles, o_dbus_cyc high 4 cycles, then 8 EXEC cycles with o_cnt 0,4..28; o_done on o_cnt=28.
- Spurious i_ibus_ack during EXEC and spurious i_dbus_ack during INIT -> no o_dec_en, no state change, counter unaffected.
- i_rst_n pulled low at EXEC o_cnt=17 -> all outputs 0 immediately; after release o_ibus_cyc=1 one cycle later with o_cnt=0.
- Watchdog on, TIMEOUT=5, ibus never acks -> o_bus_err pulse at the 6th FETCH cycle, o_ibus_cyc low one cycle, then reasserted.
- Watchdog off, no ack for 1000 cycles -> o_ibus_cyc stays 1, o_bus_err stays 0.

Source files
------------

// File: rtl/serv_fetch_seq_if.sv
// Bus handshake bundle for serv_fetch_seq: instruction and data Wishbone
// request/acknowledge pairs. The sequencer is the master. The bus side is the slave.
interface serv_fetch_seq_if;
  logic ibus_cyc;
  logic ibus_ack;
  logic dbus_cyc;
  logic dbus_ack;

  modport master (output ibus_cyc, output dbus_cyc, input ibus_ack, input dbus_ack);
  modport slave  (input ibus_cyc, input dbus_cyc, output ibus_ack, output dbus_ack);
endinterface

// File: rtl/serv_fetch_seq.sv
// serv_fetch_seq: instruction-cycle sequencer for the bit-serial core.
// Fetches over ibus, strobes the decoder, and then steps the datapath through
// the optional init stage, the optional dbus wait and the execute stage.
// Optional bus watchdog: define SERV_FETCH_SEQ_WATCHDOG_EN. With the macro, a
// stalled fetch or data access is abandoned after TIMEOUT cycles and the
// fetch is retried.
module serv_fetch_seq #(
  parameter int W       = 1,    // bits per cycle, 1 or 4
  parameter int TIMEOUT = 255   // watchdog limit, 8-bit range
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  serv_fetch_seq_if.master     bus,
  output logic                 o_dec_en,
  input  logic                 i_two_stage_op,
  input  logic                 i_dbus_en,
  output logic [4:0]           o_cnt,
  output logic                 o_cnt_en,
  output logic                 o_init,
  output logic                 o_done,
  output logic                 o_pc_en,
  output logic                 o_bus_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_INIT, S_MEM, S_EXEC
  } state_t;

  localparam logic [4:0] CNT_STEP = 5'(W);
  localparam logic [4:0] CNT_LAST = 5'(32 - W);

  state_t     state, state_nxt;
  logic [4:0] cnt;
  logic       cnt_last;
  logic       timeout;

  assign cnt_last = (cnt == CNT_LAST);

`ifdef SERV_FETCH_SEQ_WATCHDOG_EN
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);
  logic [7:0] wd_cnt;
  logic       bus_wait;

  // Waiting means that a request is out and no acknowledge has arrived this cycle.
  assign bus_wait = ((state == S_FETCH) && !bus.ibus_ack) ||
                    ((state == S_MEM)   && !bus.dbus_ack);
  assign timeout  = bus_wait && (wd_cnt == WD_LIMIT);

  // Count the wait cycles. Outside a wait the count stays at zero, so each FETCH or MEM entry starts from zero.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)                 wd_cnt <= '0;
    else if (bus_wait && !timeout) wd_cnt <= wd_cnt + 8'd1;
    else                          wd_cnt <= '0;
  end
`else
  // Without the watchdog, a stalled bus is waited on indefinitely.
  assign timeout = 1'b0;
`endif

  // State register. Reset drops any outstanding bus cycle at once.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic. The decoder inputs are sampled only at the DECODE exit and at the end of INIT.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH:  if (bus.ibus_ack)   state_nxt = S_DECODE;
                else if (timeout)   state_nxt = S_IDLE;
      S_DECODE: state_nxt = i_two_stage_op ? S_INIT : S_EXEC;
      S_INIT:   if (cnt_last)       state_nxt = i_dbus_en ? S_MEM : S_EXEC;
      S_MEM:    if (bus.dbus_ack)   state_nxt = S_EXEC;
                else if (timeout)   state_nxt = S_IDLE;
      S_EXEC:   if (cnt_last)       state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Bit counter. It runs only in INIT and EXEC, and it wraps to zero after the last index by natural overflow.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)                               cnt <= '0;
    else if (state == S_INIT || state == S_EXEC) cnt <= cnt + CNT_STEP;
    else                                        cnt <= '0;
  end

  // Outputs are decoded from the state. The decoder strobe follows ibus ack within the same cycle.
  always_comb begin
    bus.ibus_cyc = 1'b0;
    bus.dbus_cyc = 1'b0;
    o_dec_en     = 1'b0;
    o_cnt_en     = 1'b0;
    o_init       = 1'b0;
    o_done       = 1'b0;
    case (state)
      S_FETCH: begin
        bus.ibus_cyc = 1'b1;
        o_dec_en     = bus.ibus_ack;
      end
      S_MEM:   bus.dbus_cyc = 1'b1;
      S_INIT: begin
        o_cnt_en = 1'b1;
        o_init   = 1'b1;
      end
      S_EXEC: begin
        o_cnt_en = 1'b1;
        o_done   = cnt_last;
      end
      default: ;
    endcase
  end

  assign o_cnt     = cnt;
  assign o_pc_en   = o_done;
  assign o_bus_err = timeout;

endmodule
